// File: rtl/timer_multi_cmp.sv
// Prescaled free-running timer with NUM_CMP unsigned (>=) compare channels and level IRQs.
// Optional TIMER_SNAPSHOT_EN: an MTIME_LO read latches the upper word for a tear-free MTIME_HI read.
module timer_multi_cmp #(
    parameter int CNT_W      = 64,
    parameter int NUM_CMP    = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         io_addr,
    input  logic               io_we,
    input  logic [31:0]        io_din,
    output logic [31:0]        io_dout,
    output logic [NUM_CMP-1:0] irq
);
    localparam int HI_W = CNT_W - 32;
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1'b1);

    function automatic logic [31:0] zext_hi(input logic [HI_W-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[HI_W-1:0] = v;
        return r;
    endfunction

    logic [CNT_W-1:0]      mtime_r;
    logic [CNT_W-1:0]      cmp_r [NUM_CMP];
    logic                  en_r;
    logic [PRESCALE_W-1:0] div_r;
    logic [PRESCALE_W-1:0] pcnt_r;
    logic [NUM_CMP-1:0]    ie_r;
    logic [NUM_CMP-1:0]    irq_r;
    logic [HI_W-1:0]       hi_src_s;
    logic [31:0]           rdata_s;
    logic                  wr_ctrl_s;
    logic                  wr_lo_s;
    logic                  wr_hi_s;
    logic                  tick_s;
    logic [NUM_CMP-1:0]    wr_cmp_lo_s;
    logic [NUM_CMP-1:0]    wr_cmp_hi_s;
    logic [NUM_CMP-1:0]    match_s;

    // Write decode, tick generation and raw compare results.
    always_comb begin
        wr_ctrl_s = io_we && (io_addr == 4'd2);
        wr_lo_s   = io_we && (io_addr == 4'd0);
        wr_hi_s   = io_we && (io_addr == 4'd1);
        tick_s    = en_r && (pcnt_r == div_r);
        for (int k = 0; k < NUM_CMP; k++) begin
            wr_cmp_lo_s[k] = io_we && (io_addr == ({3'(k), 1'b0} + 4'd4));
            wr_cmp_hi_s[k] = io_we && (io_addr == ({3'(k), 1'b0} + 4'd5));
            match_s[k]     = (mtime_r >= cmp_r[k]);
        end
    end

    // Control register and prescaler; a CTRL write restarts the prescale phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r   <= 1'b1;
            div_r  <= {PRESCALE_W{1'b0}};
            ie_r   <= {NUM_CMP{1'b0}};
            pcnt_r <= {PRESCALE_W{1'b0}};
        end else if (wr_ctrl_s) begin
            en_r   <= io_din[0];
            div_r  <= io_din[8 +: PRESCALE_W];
            ie_r   <= io_din[16 +: NUM_CMP];
            pcnt_r <= {PRESCALE_W{1'b0}};
        end else if (tick_s) begin
            pcnt_r <= {PRESCALE_W{1'b0}};
        end else if (en_r) begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end
    end

    // Counter: a CPU write to either half wins over the tick, without carry into the other half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_r <= {CNT_W{1'b0}};
        end else if (wr_lo_s) begin
            mtime_r[31:0] <= io_din;
        end else if (wr_hi_s) begin
            mtime_r[CNT_W-1:32] <= io_din[HI_W-1:0];
        end else if (tick_s) begin
            mtime_r <= mtime_r + CNT_ONE;
        end
    end

    // Compare registers, written one 32-bit half at a time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CMP; k++) begin
                cmp_r[k] <= {CNT_W{1'b1}};
            end
        end else begin
            for (int k = 0; k < NUM_CMP; k++) begin
                if (wr_cmp_lo_s[k]) begin
                    cmp_r[k][31:0] <= io_din;
                end
                if (wr_cmp_hi_s[k]) begin
                    cmp_r[k][CNT_W-1:32] <= io_din[HI_W-1:0];
                end
            end
        end
    end

    // Level IRQs, one cycle behind the register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= {NUM_CMP{1'b0}};
        end else begin
            irq_r <= ie_r & match_s;
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [HI_W-1:0] shadow_r;

    // Upper-word shadow: captured on an MTIME_LO read decode, loaded by an MTIME_HI write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r <= {HI_W{1'b0}};
        end else if (wr_hi_s) begin
            shadow_r <= io_din[HI_W-1:0];
        end else if (!io_we && (io_addr == 4'd0)) begin
            shadow_r <= mtime_r[CNT_W-1:32];
        end
    end

    assign hi_src_s = shadow_r;
`else
    assign hi_src_s = mtime_r[CNT_W-1:32];
`endif

    // Read mux; unmapped indices return zero.
    always_comb begin
        rdata_s = 32'd0;
        case (io_addr)
            4'd0: rdata_s = mtime_r[31:0];
            4'd1: rdata_s = zext_hi(hi_src_s);
            4'd2: begin
                rdata_s[0]               = en_r;
                rdata_s[8 +: PRESCALE_W] = div_r;
                rdata_s[16 +: NUM_CMP]   = ie_r;
            end
            4'd3: rdata_s[NUM_CMP-1:0] = match_s;
            default: begin
                for (int k = 0; k < NUM_CMP; k++) begin
                    if (io_addr == ({3'(k), 1'b0} + 4'd4)) begin
                        rdata_s = cmp_r[k][31:0];
                    end else if (io_addr == ({3'(k), 1'b0} + 4'd5)) begin
                        rdata_s = zext_hi(cmp_r[k][CNT_W-1:32]);
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
    end

    assign io_dout = rdata_s;
    assign irq     = irq_r;

endmodule

// File: tb/tb_timer_multi_cmp.sv
// Self-checking bench for timer_multi_cmp (CNT_W=40, NUM_CMP=2) using an expected-value queue.
module tb_timer_multi_cmp;
    localparam int CNT_W      = 40;
    localparam int NUM_CMP    = 2;
    localparam int PRESCALE_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         io_addr;
    logic               io_we;
    logic [31:0]        io_din;
    logic [31:0]        io_dout;
    logic [NUM_CMP-1:0] irq;

    int          test_cnt = 0;
    int          fail_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp_v;
    logic [31:0] v1;

    timer_multi_cmp #(.CNT_W(CNT_W), .NUM_CMP(NUM_CMP), .PRESCALE_W(PRESCALE_W)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_we(io_we),
        .io_din(io_din), .io_dout(io_dout), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired: tests=%0d", test_cnt);
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr = a; io_we = 1'b1; io_din = d;
        @(negedge clk);
        io_we = 1'b0; io_addr = 4'd3;
    endtask

    task automatic peek(input logic [3:0] a);
        io_addr = a;
        #1 got = io_dout;
    endtask

    task automatic test_reset;
        reset = 1'b1; io_we = 1'b0; io_addr = 4'd3; io_din = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(32'd10); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got < exp_v - 32'd1 || got > exp_v + 32'd1) begin fail_cnt++; $display("FAIL reset_mtime_lo got=%0d want=%0d+-1", got, exp_v); end
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL reset_irq got=%h want=%h", got, exp_v); end
        peek(4'd3);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL reset_status got=%h want=%h", got, exp_v); end
        for (int a = 4; a < 8; a++) begin
            @(negedge clk);
            exp_q.push_back((a % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF);
            peek(4'(a));
            exp_v = exp_q.pop_front(); test_cnt++;
            if (got !== exp_v) begin fail_cnt++; $display("FAIL reset_cmp[%0d] got=%h want=%h", a, got, exp_v); end
        end
        @(negedge clk);
        exp_q.push_back(32'h0000_0001);
        peek(4'd2);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL reset_ctrl got=%h want=%h", got, exp_v); end
        wr(4'd8, 32'hDEAD_BEEF);
        exp_q.push_back(32'd0);
        peek(4'd8);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL unmapped_read got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_prescaler;
        wr(4'd2, 32'h0000_0301);
        @(negedge clk);
        peek(4'd0); v1 = got;
        exp_q.push_back(v1 + 32'd10);
        repeat (40) @(negedge clk);
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL prescale_div3 got=%0d want=%0d", got, exp_v); end
        wr(4'd2, 32'h0000_0300);
        exp_q.push_back(32'h0000_0300);
        peek(4'd2);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL ctrl_readback got=%h want=%h", got, exp_v); end
        @(negedge clk);
        peek(4'd0); v1 = got;
        exp_q.push_back(v1);
        repeat (20) @(negedge clk);
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL frozen_when_disabled got=%0d want=%0d", got, exp_v); end
    endtask

    task automatic test_compare;
        wr(4'd5, 32'hFFFF_FFFF);
        wr(4'd4, 32'd100);
        wr(4'd5, 32'd0);
        wr(4'd2, 32'h0001_0001);
        wr(4'd0, 32'd90);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_q.push_back(32'd90 + 32'(i));
            exp_q.push_back((32'd90 + 32'(i) - 32'd1 >= 32'd100) ? 32'd1 : 32'd0);
            peek(4'd0);
            exp_v = exp_q.pop_front(); test_cnt++;
            if (got !== exp_v) begin fail_cnt++; $display("FAIL cmp_mtime cyc%0d got=%0d want=%0d", i, got, exp_v); end
            got = 32'(irq);
            exp_v = exp_q.pop_front(); test_cnt++;
            if (got !== exp_v) begin fail_cnt++; $display("FAIL cmp_irq cyc%0d got=%h want=%h", i, got, exp_v); end
        end
        wr(4'd4, 32'd1000);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL irq_clear_t1 got=%h want=%h", got, exp_v); end
        peek(4'd3);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL status_after_cmp_write got=%h want=%h", got, exp_v); end
        @(negedge clk);
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL irq_clear_t2 got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_carry;
        wr(4'd1, 32'd0);
        wr(4'd0, 32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL write_on_tick got=%h want=%h", got, exp_v); end
        @(negedge clk);
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL carry_lo got=%h want=%h", got, exp_v); end
        @(negedge clk);
        peek(4'd1);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL carry_hi got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_wrap;
        wr(4'd7, 32'hFFFF_FFFF);
        wr(4'd6, 32'd5);
        wr(4'd7, 32'd0);
        exp_q.push_back(32'd3); exp_q.push_back(32'd1);
        peek(4'd3);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL status_both got=%h want=%h", got, exp_v); end
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL ie_gating got=%h want=%h", got, exp_v); end
        wr(4'd2, 32'h0003_0001);
        @(negedge clk);
        exp_q.push_back(32'd3);
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL irq_both got=%h want=%h", got, exp_v); end
        wr(4'd1, 32'hFFFF_FFFF);
        wr(4'd0, 32'hFFFF_FFFE);
        exp_q.push_back(32'h0000_00FF); exp_q.push_back(32'hFFFF_FFFE);
        peek(4'd1);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL hi_truncate got=%h want=%h", got, exp_v); end
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL pre_wrap_lo got=%h want=%h", got, exp_v); end
        repeat (2) @(negedge clk);
        exp_q.push_back(32'd0); exp_q.push_back(32'd3); exp_q.push_back(32'd0);
        peek(4'd3);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL wrap_status got=%h want=%h", got, exp_v); end
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL wrap_irq_t0 got=%h want=%h", got, exp_v); end
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL wrap_lo got=%h want=%h", got, exp_v); end
        @(negedge clk);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL wrap_irq_t1 got=%h want=%h", got, exp_v); end
        peek(4'd1);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL wrap_hi got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_snapshot;
        wr(4'd1, 32'd0);
        wr(4'd0, 32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
`ifdef TIMER_SNAPSHOT_EN
        exp_q.push_back(32'd0);
`else
        exp_q.push_back(32'd1);
`endif
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL snap_lo got=%h want=%h", got, exp_v); end
        @(posedge clk);
        #1 io_addr = 4'd3;
        repeat (5) @(negedge clk);
        peek(4'd1);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL snap_hi got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        exp_q.push_back(32'd3); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL pre_reset_irq got=%h want=%h", got, exp_v); end
        #2 reset = 1'b1;
        #1 got = 32'(irq);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL async_reset_irq got=%h want=%h", got, exp_v); end
        peek(4'd0);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL async_reset_mtime got=%h want=%h", got, exp_v); end
        @(negedge clk);
        peek(4'd2);
        exp_v = exp_q.pop_front(); test_cnt++;
        if (got !== exp_v) begin fail_cnt++; $display("FAIL async_reset_ctrl got=%h want=%h", got, exp_v); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_compare();
        test_carry();
        test_wrap();
        test_snapshot();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
